// File: rtl/vend_session_ctrl_pkg.sv
// Shared types and defaults for the vending session controller: FSM state encoding,
// default price table and a price lookup helper.
package vend_session_ctrl_pkg;

    typedef enum logic [1:0] {StIdle, StCredit, StVend, StChange} vend_state_e;

    localparam int unsigned DefCreditW    = 6;
    localparam int unsigned DefMaxCredit  = 60;
    localparam int unsigned DefTimeoutCyc = 1000;

    localparam logic [3:0] DefPrice0 = 4'd5;
    localparam logic [3:0] DefPrice1 = 4'd7;
    localparam logic [3:0] DefPrice2 = 4'd10;
    localparam logic [3:0] DefPrice3 = 4'd12;

    typedef logic [3:0][3:0] price_tbl_t;

    function automatic logic [3:0] price_of(price_tbl_t tbl, logic [1:0] item);
        return tbl[item];
    endfunction

endpackage

// File: rtl/vend_session_ctrl_if.sv
// Coin/keypad/dispenser/change bundle between the front-end and the session controller.
// master = front-end side (drives requests), slave = controller.
interface vend_session_ctrl_if #(
    parameter int unsigned CREDIT_W = 6
);
    logic                coin_valid;
    logic [3:0]          coin_amt;
    logic                coin_reject;
    logic                sel_valid;
    logic [1:0]          item_code;
    logic                sel_short;
    logic                cancel;
    logic                vend_req;
    logic [1:0]          vend_item;
    logic                vend_ack;
    logic                chg_valid;
    logic [3:0]          chg_amt;
    logic                chg_ready;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    modport master (
        output coin_valid, coin_amt, sel_valid, item_code, cancel, vend_ack, chg_ready,
        input  coin_reject, sel_short, vend_req, vend_item, chg_valid, chg_amt, credit, busy
    );

    modport slave (
        input  coin_valid, coin_amt, sel_valid, item_code, cancel, vend_ack, chg_ready,
        output coin_reject, sel_short, vend_req, vend_item, chg_valid, chg_amt, credit, busy
    );

endinterface

// File: rtl/vend_session_ctrl_timer.sv
// Idle-timeout counter: counts enabled cycles since the last clear and flags expiry
// combinationally on the cycle the count sits at TIMEOUT_CYC-1.
module vend_session_ctrl_timer #(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC);
    localparam logic [CntW-1:0] Last = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && cnt_q != Last) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired_o = en_i && !clr_i && (cnt_q == Last);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vend_session_ctrl.sv
// Vending session sequencer: accumulates coin credit, validates selections, runs the
// dispenser req/ack handshake and pays change back in chunks of at most 15 units.
module vend_session_ctrl
    import vend_session_ctrl_pkg::*;
#(
    parameter int unsigned CREDIT_W    = DefCreditW,
    parameter int unsigned MAX_CREDIT  = DefMaxCredit,
    parameter logic [3:0]  PRICE0      = DefPrice0,
    parameter logic [3:0]  PRICE1      = DefPrice1,
    parameter logic [3:0]  PRICE2      = DefPrice2,
    parameter logic [3:0]  PRICE3      = DefPrice3,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
    input logic              clk,
    input logic              reset_n,
    vend_session_ctrl_if.slave bus_io
);
    localparam price_tbl_t PriceTbl = {PRICE3, PRICE2, PRICE1, PRICE0};
    localparam logic [CREDIT_W:0] MaxCredit = (CREDIT_W + 1)'(MAX_CREDIT);

    function automatic logic [3:0] chunk(logic [CREDIT_W-1:0] c);
        return (c > CREDIT_W'(15)) ? 4'd15 : c[3:0];
    endfunction

    vend_state_e         state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic                coin_reject_q, sel_short_q, vend_req_q, chg_valid_q, busy_q;
    logic [1:0]          vend_item_q;
    logic [3:0]          chg_amt_q;

    logic [3:0]          sel_price;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_present, coin_fits, sel_ok, coin_accept, tmr_clr, tmr_expired;
    logic [CREDIT_W-1:0] vend_rem, chg_rem;

    always_comb begin
        sel_price    = price_of(PriceTbl, bus_io.item_code);
        coin_sum     = {1'b0, credit_q} + (CREDIT_W + 1)'(bus_io.coin_amt);
        coin_present = bus_io.coin_valid && (bus_io.coin_amt != 4'd0);
        coin_fits    = coin_sum <= MaxCredit;
        sel_ok       = credit_q >= CREDIT_W'(sel_price);
        // An accepted selection or a cancel in the same cycle takes precedence over the coin.
        coin_accept  = (state_q == StCredit) && coin_present && coin_fits && !bus_io.cancel &&
                       !(bus_io.sel_valid && sel_ok);
        tmr_clr      = (state_q != StCredit) || bus_io.sel_valid || coin_accept;
        vend_rem     = credit_q - CREDIT_W'(price_of(PriceTbl, vend_item_q));
        chg_rem      = credit_q - CREDIT_W'(chg_amt_q);
    end

    vend_session_ctrl_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .clr_i     (tmr_clr),
        .en_i      (state_q == StCredit),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            credit_q      <= '0;
            coin_reject_q <= 1'b0;
            sel_short_q   <= 1'b0;
            vend_req_q    <= 1'b0;
            vend_item_q   <= 2'd0;
            chg_valid_q   <= 1'b0;
            chg_amt_q     <= 4'd0;
            busy_q        <= 1'b0;
        end else begin
            coin_reject_q <= 1'b0;
            sel_short_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (coin_present) begin
                        credit_q <= CREDIT_W'(bus_io.coin_amt);
                        state_q  <= StCredit;
                    end
                    if (bus_io.sel_valid && sel_price != 4'd0) sel_short_q <= 1'b1;
                end
                StCredit: begin
                    if (bus_io.cancel || (tmr_expired && !coin_accept)) begin
                        state_q     <= StChange;
                        chg_valid_q <= 1'b1;
                        chg_amt_q   <= chunk(credit_q);
                        busy_q      <= 1'b1;
                    end else if (bus_io.sel_valid && sel_ok) begin
                        state_q     <= StVend;
                        vend_req_q  <= 1'b1;
                        vend_item_q <= bus_io.item_code;
                        busy_q      <= 1'b1;
                    end else begin
                        if (bus_io.sel_valid) sel_short_q <= 1'b1;
                        if (coin_accept) credit_q <= coin_sum[CREDIT_W-1:0];
                    end
                    if (coin_present && !coin_accept) coin_reject_q <= 1'b1;
                end
                StVend: begin
                    if (bus_io.vend_ack) begin
                        credit_q   <= vend_rem;
                        vend_req_q <= 1'b0;
                        if (vend_rem != '0) begin
                            state_q     <= StChange;
                            chg_valid_q <= 1'b1;
                            chg_amt_q   <= chunk(vend_rem);
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                    if (coin_present) coin_reject_q <= 1'b1;
                end
                StChange: begin
                    if (bus_io.chg_ready) begin
                        credit_q <= chg_rem;
                        if (chg_rem == '0) begin
                            state_q     <= StIdle;
                            chg_valid_q <= 1'b0;
                            chg_amt_q   <= 4'd0;
                            busy_q      <= 1'b0;
                        end else begin
                            chg_amt_q <= chunk(chg_rem);
                        end
                    end
                    if (coin_present) coin_reject_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.coin_reject = coin_reject_q;
    assign bus_io.sel_short   = sel_short_q;
    assign bus_io.vend_req    = vend_req_q;
    assign bus_io.vend_item   = vend_item_q;
    assign bus_io.chg_valid   = chg_valid_q;
    assign bus_io.chg_amt     = chg_amt_q;
    assign bus_io.credit      = credit_q;
    assign bus_io.busy        = busy_q;

endmodule

// File: tb/tb_vend_session_ctrl.sv
// Directed bench for vend_session_ctrl: one task per scenario with hand-computed expectations.
module tb_vend_session_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    vend_session_ctrl_if #(.CREDIT_W(6)) vif ();

    vend_session_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus_io  (vif.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        vif.coin_valid = 1'b0;
        vif.coin_amt   = 4'd0;
        vif.sel_valid  = 1'b0;
        vif.item_code  = 2'd0;
        vif.cancel     = 1'b0;
        vif.vend_ack   = 1'b0;
        vif.chg_ready  = 1'b0;
    endtask

    task automatic coin(input logic [3:0] amt);
        vif.coin_valid = 1'b1;
        vif.coin_amt   = amt;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) tick();
        checks++; if ({vif.coin_reject, vif.sel_short, vif.vend_req, vif.chg_valid, vif.busy} !== 5'b0)
            begin errors++; $display("FAIL reset_flags: got %b want 00000",
            {vif.coin_reject, vif.sel_short, vif.vend_req, vif.chg_valid, vif.busy}); end
        checks++; if (vif.credit !== 6'd0 || vif.chg_amt !== 4'd0 || vif.vend_item !== 2'd0)
            begin errors++; $display("FAIL reset_data: credit %0d chg_amt %0d item %0d want 0",
            vif.credit, vif.chg_amt, vif.vend_item); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_idle();
        // zero-value coin, cancel and stray ack/ready are all no-ops in IDLE
        vif.coin_valid = 1'b1; vif.coin_amt = 4'd0; vif.cancel = 1'b1;
        vif.vend_ack = 1'b1; vif.chg_ready = 1'b1;
        tick(); clear_inputs();
        checks++; if (vif.coin_reject !== 1'b0 || vif.credit !== 6'd0 || vif.busy !== 1'b0)
            begin errors++; $display("FAIL idle_noop: reject %0d credit %0d busy %0d want 0 0 0",
            vif.coin_reject, vif.credit, vif.busy); end
        vif.sel_valid = 1'b1; vif.item_code = 2'd1;
        tick(); clear_inputs();
        checks++; if (vif.sel_short !== 1'b1 || vif.vend_req !== 1'b0)
            begin errors++; $display("FAIL idle_sel_short: short %0d req %0d want 1 0",
            vif.sel_short, vif.vend_req); end
    endtask

    task automatic test_vend_change();
        coin(4'd5);
        coin(4'd3);
        checks++; if (vif.credit !== 6'd8) begin errors++;
            $display("FAIL t1_credit_sum: got %0d want 8", vif.credit); end
        vif.sel_valid = 1'b1; vif.item_code = 2'd0;
        tick(); clear_inputs();
        checks++; if (vif.vend_req !== 1'b1 || vif.vend_item !== 2'd0 || vif.busy !== 1'b1)
            begin errors++; $display("FAIL t1_vend: req %0d item %0d busy %0d want 1 0 1",
            vif.vend_req, vif.vend_item, vif.busy); end
        tick();
        checks++; if (vif.vend_req !== 1'b1) begin errors++;
            $display("FAIL t1_req_held: got %0d want 1", vif.vend_req); end
        vif.vend_ack = 1'b1;
        tick(); clear_inputs();
        checks++; if (vif.vend_req !== 1'b0 || vif.credit !== 6'd3 || vif.chg_valid !== 1'b1 ||
            vif.chg_amt !== 4'd3) begin errors++;
            $display("FAIL t1_after_ack: req %0d credit %0d cv %0d amt %0d want 0 3 1 3",
            vif.vend_req, vif.credit, vif.chg_valid, vif.chg_amt); end
        vif.chg_ready = 1'b1;
        tick(); clear_inputs();
        checks++; if (vif.chg_valid !== 1'b0 || vif.credit !== 6'd0 || vif.busy !== 1'b0)
            begin errors++; $display("FAIL t1_idle: cv %0d credit %0d busy %0d want 0 0 0",
            vif.chg_valid, vif.credit, vif.busy); end
    endtask

    task automatic test_short_select();
        coin(4'd4);
        vif.sel_valid = 1'b1; vif.item_code = 2'd2;
        tick(); clear_inputs();
        checks++; if (vif.sel_short !== 1'b1 || vif.credit !== 6'd4 || vif.vend_req !== 1'b0)
            begin errors++; $display("FAIL t2_short: short %0d credit %0d req %0d want 1 4 0",
            vif.sel_short, vif.credit, vif.vend_req); end
        tick();
        checks++; if (vif.sel_short !== 1'b0) begin errors++;
            $display("FAIL t2_short_pulse: got %0d want 0", vif.sel_short); end
        coin(4'd8);
        vif.sel_valid = 1'b1; vif.item_code = 2'd2;
        tick(); clear_inputs();
        checks++; if (vif.vend_req !== 1'b1 || vif.vend_item !== 2'd2 || vif.credit !== 6'd12)
            begin errors++; $display("FAIL t2_vend: req %0d item %0d credit %0d want 1 2 12",
            vif.vend_req, vif.vend_item, vif.credit); end
        vif.vend_ack = 1'b1;
        tick(); clear_inputs();
        checks++; if (vif.chg_amt !== 4'd2 || vif.credit !== 6'd2 || vif.chg_valid !== 1'b1)
            begin errors++; $display("FAIL t2_change: amt %0d credit %0d cv %0d want 2 2 1",
            vif.chg_amt, vif.credit, vif.chg_valid); end
        vif.chg_ready = 1'b1;
        tick(); clear_inputs();
    endtask

    task automatic test_max_credit_cancel();
        logic [5:0] exp_credit;
        for (int i = 0; i < 4; i++) coin(4'd15);
        checks++; if (vif.credit !== 6'd60) begin errors++;
            $display("FAIL t3_full: got %0d want 60", vif.credit); end
        coin(4'd1);
        checks++; if (vif.coin_reject !== 1'b1 || vif.credit !== 6'd60) begin errors++;
            $display("FAIL t3_reject: reject %0d credit %0d want 1 60", vif.coin_reject,
            vif.credit); end
        vif.cancel = 1'b1;
        tick(); clear_inputs();
        exp_credit = 6'd60;
        vif.chg_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (vif.chg_valid !== 1'b1 || vif.chg_amt !== 4'd15 ||
                vif.credit !== exp_credit) begin errors++;
                $display("FAIL t3_chunk%0d: cv %0d amt %0d credit %0d want 1 15 %0d", i,
                vif.chg_valid, vif.chg_amt, vif.credit, exp_credit); end
            tick();
            exp_credit = exp_credit - 6'd15;
        end
        clear_inputs();
        checks++; if (vif.chg_valid !== 1'b0 || vif.credit !== 6'd0 || vif.busy !== 1'b0)
            begin errors++; $display("FAIL t3_idle: cv %0d credit %0d busy %0d want 0 0 0",
            vif.chg_valid, vif.credit, vif.busy); end
    endtask

    task automatic test_sel_beats_coin();
        coin(4'd12);
        vif.sel_valid = 1'b1; vif.item_code = 2'd3;
        vif.coin_valid = 1'b1; vif.coin_amt = 4'd5;
        tick(); clear_inputs();
        checks++; if (vif.vend_req !== 1'b1 || vif.vend_item !== 2'd3 ||
            vif.coin_reject !== 1'b1 || vif.credit !== 6'd12) begin errors++;
            $display("FAIL t4_vend: req %0d item %0d reject %0d credit %0d want 1 3 1 12",
            vif.vend_req, vif.vend_item, vif.coin_reject, vif.credit); end
        vif.coin_valid = 1'b1; vif.coin_amt = 4'd2;
        tick(); clear_inputs();
        checks++; if (vif.coin_reject !== 1'b1 || vif.credit !== 6'd12) begin errors++;
            $display("FAIL t4_vend_coin: reject %0d credit %0d want 1 12", vif.coin_reject,
            vif.credit); end
        vif.vend_ack = 1'b1;
        tick(); clear_inputs();
        checks++; if (vif.credit !== 6'd0 || vif.chg_valid !== 1'b0 || vif.busy !== 1'b0 ||
            vif.vend_req !== 1'b0) begin errors++;
            $display("FAIL t4_idle: credit %0d cv %0d busy %0d req %0d want 0 0 0 0",
            vif.credit, vif.chg_valid, vif.busy, vif.vend_req); end
    endtask

    task automatic test_timeout();
        coin(4'd7);
        repeat (999) tick();
        checks++; if (vif.chg_valid !== 1'b0 || vif.credit !== 6'd7) begin errors++;
            $display("FAIL t5_early: cv %0d credit %0d want 0 7", vif.chg_valid, vif.credit); end
        tick();
        checks++; if (vif.chg_valid !== 1'b1 || vif.chg_amt !== 4'd7) begin errors++;
            $display("FAIL t5_timeout: cv %0d amt %0d want 1 7", vif.chg_valid, vif.chg_amt); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (vif.chg_valid !== 1'b1 || vif.credit !== 6'd7) begin errors++;
                $display("FAIL t5_hold%0d: cv %0d credit %0d want 1 7", i, vif.chg_valid,
                vif.credit); end
        end
        vif.chg_ready = 1'b1;
        tick(); clear_inputs();
        checks++; if (vif.chg_valid !== 1'b0 || vif.credit !== 6'd0) begin errors++;
            $display("FAIL t5_idle: cv %0d credit %0d want 0 0", vif.chg_valid, vif.credit); end
    endtask

    task automatic test_reset_mid_vend();
        coin(4'd10);
        vif.sel_valid = 1'b1; vif.item_code = 2'd1;
        tick(); clear_inputs();
        checks++; if (vif.vend_req !== 1'b1) begin errors++;
            $display("FAIL t6_vend: req %0d want 1", vif.vend_req); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({vif.vend_req, vif.busy, vif.chg_valid} !== 3'b0 || vif.credit !== 6'd0)
            begin errors++; $display("FAIL t6_async_reset: flags %b credit %0d want 000 0",
            {vif.vend_req, vif.busy, vif.chg_valid}, vif.credit); end
        tick();
        reset_n = 1'b1;
        tick();
        vif.vend_ack = 1'b1;
        tick(); clear_inputs();
        checks++; if ({vif.vend_req, vif.busy, vif.chg_valid} !== 3'b0 || vif.credit !== 6'd0)
            begin errors++; $display("FAIL t6_late_ack: flags %b credit %0d want 000 0",
            {vif.vend_req, vif.busy, vif.chg_valid}, vif.credit); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_vend_change();
        test_short_select();
        test_max_credit_cancel();
        test_sel_beats_coin();
        test_timeout();
        test_reset_mid_vend();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
